// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared memory-subsystem definitions: block address/data types, request
// type and the owner of an in-flight memory request.
package mem_ctrl_arbiter_pkg;

  localparam int unsigned MAIN_MEM_BLOCK_ADDR_WIDTH = 26;
  localparam int unsigned BLOCK_DATA_WIDTH          = 512;

  typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_ctrl_arbiter_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_aH,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates icache/dcache block requests onto a single memory port, one
// request in flight, icache has fixed priority.
//
// state       | meaning
// S_IDLE      | accepting a new request from icache (priority) or dcache
// S_ISSUE     | holding mem_req_* stable until memory accepts
// S_WAIT_RESP | read outstanding; route mem response to owner
module mem_ctrl_arbiter
  import mem_ctrl_arbiter_pkg::*;
#(
  parameter int BLOCK_ADDR_WIDTH = 26,
  parameter int BLOCK_DATA_WIDTH = 512,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst_aH,
  input  logic                        flush,
  input  logic                        ic_req_valid,
  output logic                        ic_req_ready,
  input  logic [BLOCK_ADDR_WIDTH-1:0] ic_req_block_addr,
  output logic                        ic_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] ic_resp_block_data,
  input  logic                        dc_req_valid,
  output logic                        dc_req_ready,
  input  req_type_t                   dc_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dc_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dc_req_block_data,
  output logic                        dc_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dc_resp_block_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output req_type_t                   mem_req_type,
  output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
  input  logic                        mem_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,
  output logic [CNT_WIDTH-1:0]        ic_grant_cnt,
  output logic [CNT_WIDTH-1:0]        dc_grant_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  req_type_t                   hold_type_q;
  logic [BLOCK_ADDR_WIDTH-1:0] hold_addr_q;
  logic [BLOCK_DATA_WIDTH-1:0] hold_data_q;
  owner_t                      owner_q;
  logic                        drop_q, drop_d;
  logic                        ic_accept, dc_accept;

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Icache carries no write data, so its holding data is cleared.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      hold_type_q <= REQ_READ;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      owner_q     <= OWNER_IC;
    end else if (ic_accept) begin
      hold_type_q <= REQ_READ;
      hold_addr_q <= ic_req_block_addr;
      hold_data_q <= '0;
      owner_q     <= OWNER_IC;
    end else if (dc_accept) begin
      hold_type_q <= dc_req_type;
      hold_addr_q <= dc_req_block_addr;
      hold_data_q <= dc_req_block_data;
      owner_q     <= OWNER_DC;
    end
  end

  always_comb begin
    state_d       = state_q;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    ic_resp_valid = 1'b0;
    dc_resp_valid = 1'b0;
    ic_accept     = 1'b0;
    dc_accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ic_req_ready = 1'b1;
        dc_req_ready = ~ic_req_valid;
        ic_accept    = ic_req_valid;
        dc_accept    = dc_req_valid & ~ic_req_valid;
        if (ic_accept || dc_accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = (hold_type_q == REQ_WRITE) ? S_IDLE : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          if (owner_q == OWNER_DC) dc_resp_valid = 1'b1;
          else                     ic_resp_valid = ~drop_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed icache request still completes; only its fill is suppressed.
    drop_d = drop_q;
    if (state_d == S_IDLE) begin
      drop_d = 1'b0;
    end else if (flush && (owner_q == OWNER_IC) && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
    end
  end

  assign mem_req_type       = hold_type_q;
  assign mem_req_block_addr = hold_addr_q;
  assign mem_req_block_data = hold_data_q;

  assign ic_resp_block_data = ic_resp_valid ? mem_resp_block_data : '0;
  assign dc_resp_block_data = dc_resp_valid ? mem_resp_block_data : '0;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ic_grant_cnt (
    .clk    (clk),
    .rst_aH (rst_aH),
    .inc    (ic_accept),
    .count  (ic_grant_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_dc_grant_cnt (
    .clk    (clk),
    .rst_aH (rst_aH),
    .inc    (dc_accept),
    .count  (dc_grant_cnt)
  );

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Bench for mem_ctrl_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level reference model.
module tb_mem_ctrl_arbiter;
  import mem_ctrl_arbiter_pkg::*;

  localparam int AW   = 26;
  localparam int DW   = 512;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [DW-1:0] wide_t;

  logic          clk = 1'b0;
  logic          rst_aH;
  logic          flush;
  logic          ic_req_valid, ic_req_ready;
  logic [AW-1:0] ic_req_block_addr;
  logic          ic_resp_valid;
  logic [DW-1:0] ic_resp_block_data;
  logic          dc_req_valid, dc_req_ready;
  req_type_t     dc_req_type;
  logic [AW-1:0] dc_req_block_addr;
  logic [DW-1:0] dc_req_block_data;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_resp_block_data;
  logic          mem_req_valid, mem_req_ready;
  req_type_t     mem_req_type;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_block_data;
  logic [CW-1:0] ic_grant_cnt, dc_grant_cnt;

  always #5 clk = ~clk;

  mem_ctrl_arbiter #(
    .BLOCK_ADDR_WIDTH (AW),
    .BLOCK_DATA_WIDTH (DW),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk                 (clk),
    .rst_aH              (rst_aH),
    .flush               (flush),
    .ic_req_valid        (ic_req_valid),
    .ic_req_ready        (ic_req_ready),
    .ic_req_block_addr   (ic_req_block_addr),
    .ic_resp_valid       (ic_resp_valid),
    .ic_resp_block_data  (ic_resp_block_data),
    .dc_req_valid        (dc_req_valid),
    .dc_req_ready        (dc_req_ready),
    .dc_req_type         (dc_req_type),
    .dc_req_block_addr   (dc_req_block_addr),
    .dc_req_block_data   (dc_req_block_data),
    .dc_resp_valid       (dc_resp_valid),
    .dc_resp_block_data  (dc_resp_block_data),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_type        (mem_req_type),
    .mem_req_block_addr  (mem_req_block_addr),
    .mem_req_block_data  (mem_req_block_data),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_block_data (mem_resp_block_data),
    .ic_grant_cnt        (ic_grant_cnt),
    .dc_grant_cnt        (dc_grant_cnt)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input wide_t got, input wide_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one pending transaction record plus grant tallies.
  bit          m_busy, m_issued, m_is_dc, m_write, m_drop;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_ic_cnt, m_dc_cnt;

  function automatic int bump(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic wide_t rand_block();
    wide_t d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_is_dc = 0; m_write = 0; m_drop = 0;
    m_addr = '0; m_data = '0; m_ic_cnt = 0; m_dc_cnt = 0;
  endtask

  task automatic model_update();
    if (!m_busy) begin
      if (ic_req_valid) begin
        m_busy = 1; m_issued = 0; m_is_dc = 0; m_write = 0;
        m_addr = ic_req_block_addr; m_data = '0;
        m_ic_cnt = bump(m_ic_cnt);
      end else if (dc_req_valid) begin
        m_busy = 1; m_issued = 0; m_is_dc = 1;
        m_write = (dc_req_type == REQ_WRITE);
        m_addr = dc_req_block_addr; m_data = dc_req_block_data;
        m_dc_cnt = bump(m_dc_cnt);
      end
    end else begin
      if (flush && !m_is_dc) m_drop = 1;
      if (!m_issued) begin
        if (mem_req_ready) begin
          if (m_write) begin m_busy = 0; m_drop = 0; end
          else m_issued = 1;
        end
      end else if (mem_resp_valid) begin
        m_busy = 0; m_drop = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit e_mem  = m_busy && !m_issued;
    bit e_icr  = m_busy && m_issued && mem_resp_valid && !m_is_dc && !m_drop;
    bit e_dcr  = m_busy && m_issued && mem_resp_valid && m_is_dc;
    check_val("ic_req_ready", wide_t'(ic_req_ready), wide_t'(!m_busy));
    check_val("dc_req_ready", wide_t'(dc_req_ready), wide_t'(!m_busy && !ic_req_valid));
    check_val("mem_req_valid", wide_t'(mem_req_valid), wide_t'(e_mem));
    check_val("ic_resp_valid", wide_t'(ic_resp_valid), wide_t'(e_icr));
    check_val("dc_resp_valid", wide_t'(dc_resp_valid), wide_t'(e_dcr));
    check_val("ic_grant_cnt", wide_t'(ic_grant_cnt), wide_t'(m_ic_cnt));
    check_val("dc_grant_cnt", wide_t'(dc_grant_cnt), wide_t'(m_dc_cnt));
    if (e_mem) begin
      check_val("mem_req_type", wide_t'(mem_req_type), wide_t'(m_write));
      check_val("mem_req_addr", wide_t'(mem_req_block_addr), wide_t'(m_addr));
      if (m_write) check_val("mem_req_data", mem_req_block_data, m_data);
    end
    if (e_icr) check_val("ic_resp_data", ic_resp_block_data, mem_resp_block_data);
    if (e_dcr) check_val("dc_resp_data", dc_resp_block_data, mem_resp_block_data);
  endtask

  // Entered at a falling edge with inputs set; leaves at the next falling edge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; ic_req_valid = 0; ic_req_block_addr = '0;
    dc_req_valid = 0; dc_req_type = REQ_READ; dc_req_block_addr = '0;
    dc_req_block_data = '0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_block_data = '0;
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic reset_check();
    rst_aH = 1;
    ic_req_valid = 1'($urandom_range(0, 1));
    mem_resp_valid = 1; mem_resp_block_data = rand_block();
    #1;
    model_reset();
    check_outputs();
    check_val("rst_mem_type", wide_t'(mem_req_type), '0);
    check_val("rst_mem_addr", wide_t'(mem_req_block_addr), '0);
    check_val("rst_mem_data", mem_req_block_data, '0);
    check_val("rst_ic_rdata", ic_resp_block_data, '0);
    check_val("rst_dc_rdata", dc_resp_block_data, '0);
    @(posedge clk);
    @(negedge clk);
    rst_aH = 0;
    idle_inputs();
  endtask

  task automatic randomize_inputs();
    flush             = ($urandom_range(0, 6) == 0);
    ic_req_valid      = ($urandom_range(0, 2) == 0);
    ic_req_block_addr = AW'($urandom);
    dc_req_valid      = ($urandom_range(0, 1) == 0);
    dc_req_type       = req_type_t'($urandom_range(0, 1));
    dc_req_block_addr = AW'($urandom);
    dc_req_block_data = rand_block();
    mem_req_ready     = ($urandom_range(0, 4) < 3);
    mem_resp_valid    = ($urandom_range(0, 4) < 2);
    mem_resp_block_data = rand_block();
  endtask

  initial begin
    rst_aH = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset_check();

    // IC read 0x12 with back-to-back memory: N accept, N+1 issue, N+2 fill.
    ic_req_valid = 1; ic_req_block_addr = 'h12; mem_req_ready = 1;
    step();
    ic_req_valid = 0;
    #1 check_val("t1_mem_valid", wide_t'(mem_req_valid), wide_t'(1));
    check_val("t1_mem_addr", wide_t'(mem_req_block_addr), wide_t'('h12));
    step();
    mem_resp_valid = 1; mem_resp_block_data = {64{8'hAA}};
    #1 check_val("t1_ic_resp", wide_t'(ic_resp_valid), wide_t'(1));
    check_val("t1_ic_data", ic_resp_block_data, {64{8'hAA}});
    step();
    mem_resp_valid = 0;
    #1 check_val("t1_ic_resp_end", wide_t'(ic_resp_valid), wide_t'(0));
    check_val("t1_ic_cnt", wide_t'(ic_grant_cnt), wide_t'(1));
    step();

    // Simultaneous IC/DC: IC wins, DC write to 0x3 follows.
    ic_req_valid = 1; ic_req_block_addr = 'h5;
    dc_req_valid = 1; dc_req_type = REQ_WRITE; dc_req_block_addr = 'h3;
    dc_req_block_data = rand_block(); mem_req_ready = 1;
    #1 check_val("t2_dc_ready", wide_t'(dc_req_ready), wide_t'(0));
    step();
    ic_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_resp_block_data = rand_block();
    step();
    mem_resp_valid = 0;
    step();
    dc_req_valid = 0;
    #1 check_val("t2_mem_type", wide_t'(mem_req_type), wide_t'(1));
    check_val("t2_mem_addr", wide_t'(mem_req_block_addr), wide_t'('h3));
    step();
    step();

    // Memory stalls for 5 cycles on a DC read.
    dc_req_valid = 1; dc_req_type = REQ_READ; dc_req_block_addr = 'h7;
    step();
    dc_req_valid = 0; mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1 check_val("t3_stall_addr", wide_t'(mem_req_block_addr), wide_t'('h7));
      step();
    end
    mem_req_ready = 1;
    step();
    mem_resp_valid = 1; mem_resp_block_data = rand_block();
    step();
    idle_inputs();

    // Flush during IC wait drops the fill; flush never touches DC.
    ic_req_valid = 1; ic_req_block_addr = 'h21; mem_req_ready = 1;
    step();
    ic_req_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0; mem_resp_valid = 1; mem_resp_block_data = rand_block();
    #1 check_val("t4_ic_dropped", wide_t'(ic_resp_valid), wide_t'(0));
    step();
    mem_resp_valid = 0;
    #1 check_val("t4_back_idle", wide_t'(ic_req_ready), wide_t'(1));
    dc_req_valid = 1; dc_req_type = REQ_READ; dc_req_block_addr = 'h44; flush = 1;
    step();
    dc_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_resp_block_data = rand_block();
    #1 check_val("t4_dc_kept", wide_t'(dc_resp_valid), wide_t'(1));
    step();
    idle_inputs();

    // Counter saturation at 4 bits.
    reset_check();
    mem_req_ready = 1;
    for (int i = 0; i < 20; i++) begin
      ic_req_valid = 1; ic_req_block_addr = AW'(i);
      step();
      ic_req_valid = 0;
      step();
      mem_resp_valid = 1; mem_resp_block_data = rand_block();
      step();
      mem_resp_valid = 0;
    end
    #1 check_val("t5_ic_sat", wide_t'(ic_grant_cnt), wide_t'(15));
    step();

    // Reset while waiting for a response; the late response is ignored.
    ic_req_valid = 1; ic_req_block_addr = 'h30; mem_req_ready = 1;
    step();
    ic_req_valid = 0;
    step();
    reset_check();
    mem_resp_valid = 1; mem_resp_block_data = rand_block();
    #1 check_val("t6_no_resp", wide_t'(ic_resp_valid), wide_t'(0));
    check_val("t6_idle", wide_t'(ic_req_ready), wide_t'(1));
    check_val("t6_ic_cnt", wide_t'(ic_grant_cnt), wide_t'(0));
    step();
    idle_inputs();

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset_check();
      end else begin
        randomize_inputs();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
